// File: rtl/uart_prog_loader.sv
// Framed program-image loader: decodes A5 5A CNT_LO CNT_HI DATA... CSUM from a UART byte
// stream, writes 32-bit words to CPU memory over a valid/ready port and holds the CPU in reset.
module uart_prog_loader #(
  parameter logic [31:0] BASE_WORD_ADDR = 32'h0,
  parameter int          MAX_WORDS      = 4096,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_written
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE_WAIT, ERR
  } state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [15:0]   word_idx;
  logic [31:0]   asm_reg;
  logic [7:0]    xor_reg;
  logic [1:0]    byte_idx;
  logic [TW-1:0] timer;

  logic [15:0]   len_next;
  logic [31:0]   asm_next;
  logic          word_last;
  logic          timeout_hit;
  logic          overflow;

  assign len_next    = {rx_byte, cnt[7:0]};
  assign asm_next    = {rx_byte, asm_reg[31:8]};
  assign word_last   = (word_idx == cnt - 16'd1);
  // A write accepted on the same edge frees the slot, so only an unaccepted pending write overflows.
  assign overflow    = wr_valid && !wr_ready;
  assign timeout_hit = (state != IDLE) && (state != ERR) && !rx_valid &&
                       (timer == TW'(TIMEOUT_CYCLES - 1));
  assign wr_strb     = wr_valid ? 4'hF : 4'h0;

  // NOTE: all state and registered outputs use non-blocking assignments so every branch
  // below sees the pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      word_idx      <= '0;
      asm_reg       <= '0;
      xor_reg       <= '0;
      byte_idx      <= '0;
      timer         <= '0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      cpu_hold      <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      words_written <= '0;
    end else begin
      load_done <= 1'b0;

      if (wr_valid && wr_ready) begin
        wr_valid      <= 1'b0;
        words_written <= words_written + 16'd1;
      end

      if (state == IDLE || rx_valid) timer <= '0;
      else                           timer <= timer + 1'b1;

      if (timeout_hit) begin
        state    <= ERR;
        load_err <= 1'b1;
        wr_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rx_valid && rx_byte == 8'hA5) state <= SYNC;

          SYNC: if (rx_valid) begin
            if (rx_byte == 8'h5A) begin
              state         <= LEN0;
              cpu_hold      <= 1'b1;
              load_err      <= 1'b0;
              words_written <= '0;
              xor_reg       <= '0;
              byte_idx      <= '0;
              word_idx      <= '0;
            end else if (rx_byte != 8'hA5) begin
              state <= IDLE;
            end
          end

          LEN0: if (rx_valid) begin
            cnt[7:0] <= rx_byte;
            state    <= LEN1;
          end

          LEN1: if (rx_valid) begin
            cnt[15:8] <= rx_byte;
            if (len_next == 16'd0 || {1'b0, len_next} > 17'(MAX_WORDS)) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end

          DATA: if (rx_valid) begin
            asm_reg  <= asm_next;
            xor_reg  <= xor_reg ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (overflow) begin
                state    <= ERR;
                load_err <= 1'b1;
                wr_valid <= 1'b0;
              end else begin
                wr_valid <= 1'b1;
                wr_data  <= asm_next;
                wr_addr  <= BASE_WORD_ADDR + {16'h0, word_idx};
                word_idx <= word_idx + 16'd1;
                if (word_last) state <= CSUM;
              end
            end
          end

          CSUM: if (rx_valid) begin
            if (rx_byte != xor_reg) begin
              state    <= ERR;
              load_err <= 1'b1;
              wr_valid <= 1'b0;
            end else begin
              state <= DONE_WAIT;
            end
          end

          DONE_WAIT: if (!wr_valid) begin
            state     <= IDLE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end

          // cpu_hold is left set so a partially loaded image never runs.
          ERR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
